// File: rtl/count_seq_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
//   Shared types and helpers for the count_sequencer slice.
//   - Q_W       : width of the count value driven to the seven-seg decoder
//   - state_t   : controller state (IDLE, RUN, HOLD)
//   - johnson_up / johnson_dn : one step of the 5-bit (10-state) Johnson ring
//   - johnson_legal           : 1 when a code is one of the 10 ring states
// ---------------------------------------------------------------------------
package count_seq_pkg;

    localparam int Q_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [Q_W-1:0] johnson_up(input logic [Q_W-1:0] v);
        return {v[Q_W-2:0], ~v[Q_W-1]};
    endfunction

    // Exact inverse of johnson_up.
    function automatic logic [Q_W-1:0] johnson_dn(input logic [Q_W-1:0] v);
        return {~v[0], v[Q_W-1:1]};
    endfunction

    function automatic logic johnson_legal(input logic [Q_W-1:0] v);
        case (v)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/count_sequencer_btn.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   Turns one raw, asynchronous, active-high pushbutton into a single
//   1-cycle press pulse per press.
//   Build option: BTN_DEBOUNCE_EN adds a debouncer between the synchronizer
//   and the edge detector (press latency DEBOUNCE_CYCLES+3 clk instead of 3).
//   Ports:
//     clk      in  1  system clock, rising edge
//     rst      in  1  asynchronous active-high reset
//     i_btn    in  1  raw pushbutton level
//     o_press  out 1  registered 1-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_press;

`ifdef BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // r_stable follows the synchronized level only after it has differed for
    // DEBOUNCE_CYCLES+1 consecutive samples, which lands the press pulse
    // exactly DEBOUNCE_CYCLES+3 clocks after the raw rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_press <= r_sync2 & ~r_prev;
        end
    end

    // DEBOUNCE_CYCLES has no effect without the debouncer; a nonsensical
    // value still leaves a marker block in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cfg_invalid
    end
`endif

    assign o_press = r_press;

endmodule

// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
//   Run/hold/clear controller for the 5-bit count value feeding the two-digit
//   seven-seg decoder. Steps q at CLK_HZ/TICK_HZ cycles per step in binary
//   (mod 32) or 5-bit Johnson (10-state) mode, up or down, with load/clear.
//   Build option: BTN_DEBOUNCE_EN enables button debouncing (btn_conditioner).
//   Handshake: none; buttons are raw levels, load_en is a synchronous level.
//   Ports:
//     clk             in  1   system clock, rising edge
//     rst             in  1   asynchronous active-high reset
//     btn_start_stop  in  1   raw button, each press toggles run/hold
//     btn_clear       in  1   raw button, press returns to IDLE with q=0
//     mode            in  1   0 = binary mod-32, 1 = Johnson
//     dir             in  1   1 = up, 0 = down
//     load_en         in  1   load load_val into q (IDLE/HOLD only)
//     load_val        in  5   value to load
//     q               out 5   registered count value
//     running         out 1   1 while state == RUN
//     step            out 1   1-cycle pulse when q updates from a tick
//     wrap            out 1   1-cycle pulse with step on count wrap
//     dbg_state       out 2   current controller state
// ---------------------------------------------------------------------------
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 2,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_start_stop,
    input  logic           btn_clear,
    input  logic           mode,
    input  logic           dir,
    input  logic           load_en,
    input  logic [Q_W-1:0] load_val,
    output logic [Q_W-1:0] q,
    output logic           running,
    output logic           step,
    output logic           wrap,
    output state_t         dbg_state
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic w_press_ss;
    logic w_press_clr;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_start_stop),
        .o_press (w_press_ss)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clear),
        .o_press (w_press_clr)
    );

    state_t           r_state;
    state_t           w_next_state;
    logic [Q_W-1:0]   r_q;
    logic [Q_W-1:0]   w_next_q;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_next_div;
    logic             r_running;
    logic             r_step;
    logic             r_wrap;
    logic             w_tick;
    logic             w_step;
    logic             w_wrap;
    logic [Q_W-1:0]   w_step_q;
    logic             w_step_wrap;

    assign w_tick = (r_state == RUN) && (r_div == DIV_W'(DIV - 1));

    // Value q would take on a tick. An illegal code in Johnson mode (e.g.
    // after a mode switch mid-run) resynchronises to 0 without a wrap.
    always_comb begin
        w_step_q    = r_q;
        w_step_wrap = 1'b0;
        if (mode) begin
            if (johnson_legal(r_q)) begin
                w_step_q    = dir ? johnson_up(r_q) : johnson_dn(r_q);
                w_step_wrap = (w_step_q == '0);
            end else begin
                w_step_q = '0;
            end
        end else begin
            w_step_q    = dir ? (r_q + Q_W'(1)) : (r_q - Q_W'(1));
            w_step_wrap = dir ? (r_q == '1) : (r_q == '0);
        end
    end

    // Priority: clear > load (IDLE/HOLD) > start/stop > tick.
    // A start/stop press in the tick cycle toggles state and suppresses the step.
    always_comb begin
        w_next_state = r_state;
        w_next_q     = r_q;
        w_next_div   = r_div;
        w_step       = 1'b0;
        w_wrap       = 1'b0;
        if (w_press_clr) begin
            w_next_state = IDLE;
            w_next_q     = '0;
            w_next_div   = '0;
        end else if (load_en && (r_state != RUN)) begin
            w_next_q = (mode && !johnson_legal(load_val)) ? '0 : load_val;
        end else if (w_press_ss) begin
            case (r_state)
                IDLE:    w_next_state = RUN;
                RUN:     w_next_state = HOLD;
                HOLD:    w_next_state = RUN;
                default: w_next_state = IDLE;
            endcase
            if (w_next_state == RUN) begin
                w_next_div = '0;
            end
        end else if (r_state == RUN) begin
            if (w_tick) begin
                w_next_div = '0;
                w_next_q   = w_step_q;
                w_step     = 1'b1;
                w_wrap     = w_step_wrap;
            end else begin
                w_next_div = r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_div     <= '0;
            r_running <= 1'b0;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_q       <= w_next_q;
            r_div     <= w_next_div;
            r_running <= (w_next_state == RUN);
            r_step    <= w_step;
            r_wrap    <= w_wrap;
        end
    end

    assign q         = r_q;
    assign running   = r_running;
    assign step      = r_step;
    assign wrap      = r_wrap;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
//   Directed + randomized bench for count_sequencer with CLK_HZ=8, TICK_HZ=2
//   (4 clocks per step). The reference model steps q by plain arithmetic
//   (binary) or by walking a table of the 10 Johnson codes.
// ---------------------------------------------------------------------------
module tb_count_sequencer;
    import count_seq_pkg::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_clr;
    logic       mode;
    logic       dir;
    logic       load_en;
    logic [4:0] load_val;
    logic [4:0] q;
    logic       running;
    logic       step;
    logic       wrap;
    state_t     dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int m_q      = 0;

    logic [4:0] jseq [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                              5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

    count_sequencer #(
        .CLK_HZ          (8),
        .TICK_HZ         (2),
        .DEBOUNCE_CYCLES (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_ss),
        .btn_clear      (btn_clr),
        .mode           (mode),
        .dir            (dir),
        .load_en        (load_en),
        .load_val       (load_val),
        .q              (q),
        .running        (running),
        .step           (step),
        .wrap           (wrap),
        .dbg_state      (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // reference model
    function automatic int j_index(input int v);
        for (int i = 0; i < 10; i++) begin
            if (int'(jseq[i]) == v) return i;
        end
        return -1;
    endfunction

    function automatic int model_next(input int v, input int md, input int up, output int wr);
        int i;
        wr = 0;
        if (md == 0) begin
            if (up != 0) begin
                wr = (v == 31) ? 1 : 0;
                return (v + 1) % 32;
            end
            wr = (v == 0) ? 1 : 0;
            return (v + 31) % 32;
        end
        i = j_index(v);
        if (i < 0) return 0;
        i = (up != 0) ? (i + 1) % 10 : (i + 9) % 10;
        wr = (jseq[i] == 5'd0) ? 1 : 0;
        return int'(jseq[i]);
    endfunction

    function automatic int model_load(input int v, input int md);
        if (md != 0 && j_index(v) < 0) return 0;
        return v;
    endfunction

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Button held for 2 clocks; returns 4 clocks after the rise, i.e. just
    // after the edge where the press takes effect.
    task automatic press(input int which);
        if (which == 0) btn_ss = 1'b1;
        else            btn_clr = 1'b1;
        cyc(2);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        cyc(2);
    endtask

    task automatic step_once(input string tag);
        int w;
        int nq;
        nq = model_next(m_q, int'(mode), int'(dir), w);
        cyc(1);
        check({tag, "_step"}, int'(step), 1);
        check({tag, "_q"}, int'(q), nq);
        check({tag, "_wrap"}, int'(wrap), w);
        m_q = nq;
    endtask

    task automatic run_steps(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(DIV - 1);
            check({tag, "_nostep"}, int'(step), 0);
            step_once(tag);
        end
    endtask

    task automatic do_load(input string tag, input int v);
        load_val = 5'(v);
        load_en  = 1'b1;
        cyc(1);
        load_en  = 1'b0;
        m_q = model_load(v, int'(mode));
        check(tag, int'(q), m_q);
    endtask

    task automatic expect_hold_after_tick_press(input string tag);
        press(0);
        check({tag, "_state"}, int'(dbg_state), int'(HOLD));
        check({tag, "_step"}, int'(step), 0);
        check({tag, "_q"}, int'(q), m_q);
        check({tag, "_running"}, int'(running), 0);
    endtask

    // stimulus
    initial begin
        rst = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0; mode = 1'b0; dir = 1'b1;
        load_en = 1'b0; load_val = 5'd0;
        #12;
        check("rst_q", int'(q), 0);
        check("rst_running", int'(running), 0);
        check("rst_step", int'(step), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        @(negedge clk) rst = 1'b0;
        cyc(1);

        // Binary up from 0: running latency, then 33 steps across 31->0.
        btn_ss = 1'b1;
        cyc(2);
        btn_ss = 1'b0;
        cyc(1);
        check("run_early", int'(running), 0);
        cyc(1);
        check("run_rise", int'(running), 1);
        check("run_state", int'(dbg_state), int'(RUN));
        run_steps("bin_up", 33);

        // Start/stop press in the tick cycle: HOLD, no step.
        expect_hold_after_tick_press("tick_hold");

        // Loads in HOLD, mode switch leaves q alone.
        do_load("load_hold_9", 9);
        check("load_hold_state", int'(dbg_state), int'(HOLD));
        mode = 1'b1;
        cyc(2);
        check("mode_sw_keep_q", int'(q), 9);

        // Illegal Johnson code at a tick resyncs to 0 without wrap.
        press(0);
        check("resume_running", int'(running), 1);
        run_steps("j_illegal", 1);
        run_steps("j_up", 3);

        // Load ignored while running.
        load_val = 5'd20;
        load_en  = 1'b1;
        cyc(1);
        load_en  = 1'b0;
        check("load_in_run", int'(q), m_q);
        cyc(DIV - 2);
        step_once("after_run_load");

        // Clear coincident with a tick.
        press(1);
        m_q = 0;
        check("clr_q", int'(q), 0);
        check("clr_state", int'(dbg_state), int'(IDLE));
        check("clr_step", int'(step), 0);
        check("clr_running", int'(running), 0);

        // Johnson full ring up then down.
        mode = 1'b1;
        dir  = 1'b1;
        press(0);
        run_steps("j_ring_up", 12);
        dir = 1'b0;
        run_steps("j_ring_dn", 12);
        expect_hold_after_tick_press("j_hold");
        do_load("j_load_illegal", 5);

        // Randomized segments.
        for (int it = 0; it < 8; it++) begin
            mode = 1'($urandom_range(0, 1));
            do_load("rnd_load", int'($urandom_range(0, 31)));
            mode = 1'($urandom_range(0, 1));
            dir  = 1'($urandom_range(0, 1));
            press(0);
            check("rnd_running", int'(running), 1);
            run_steps("rnd_a", int'($urandom_range(1, 6)));
            dir  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) mode = ~mode;
            run_steps("rnd_b", int'($urandom_range(1, 4)));
            expect_hold_after_tick_press("rnd_hold");
        end

        // Asynchronous reset right after a wrapping step.
        mode = 1'b0;
        dir  = 1'b0;
        do_load("pre_rst_load", 0);
        press(0);
        run_steps("pre_rst", 1);
        #2 rst = 1'b1;
        #1;
        check("arst_q", int'(q), 0);
        check("arst_running", int'(running), 0);
        check("arst_step", int'(step), 0);
        check("arst_wrap", int'(wrap), 0);
        check("arst_state", int'(dbg_state), int'(IDLE));
        @(negedge clk) rst = 1'b0;
        cyc(2);
        check("post_rst_state", int'(dbg_state), int'(IDLE));
        check("post_rst_q", int'(q), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
